// File: rtl/ifetch_queue_pkg.sv
// Shared types and decode helpers for the instruction fetch queue.
package ifetch_queue_pkg;

  localparam logic [6:0] OPCODE_B    = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  localparam int         IQ_ENTRY_WIDTH = 97;
  localparam logic [1:0] BHT_INIT       = 2'b01;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } iq_entry_t;

  typedef enum logic [1:0] {
    KIND_OTHER,
    KIND_B,
    KIND_JAL,
    KIND_JALR
  } instr_kind_e;

  function automatic instr_kind_e decode_kind(input logic [31:0] instr);
    case (instr[6:0])
      OPCODE_B:    return KIND_B;
      OPCODE_JAL:  return KIND_JAL;
      OPCODE_JALR: return KIND_JALR;
      default:     return KIND_OTHER;
    endcase
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/ifetch_queue_bht.sv
// 2-bit saturating branch history table: combinational read, clocked update.
import ifetch_queue_pkg::*;

module branch_history_table #(
  parameter int BHT_IDX_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 en,
  input  logic [BHT_IDX_W-1:0] rd_idx,
  output logic                 rd_taken,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  localparam int BHT_ENTRIES = 2 ** BHT_IDX_W;

  logic [1:0] ctr [BHT_ENTRIES];

  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= BHT_INIT;
    end else if (en && upd_en) begin
      if (upd_taken)
        ctr[upd_idx] <= (ctr[upd_idx] == 2'b11) ? 2'b11 : ctr[upd_idx] + 2'b01;
      else
        ctr[upd_idx] <= (ctr[upd_idx] == 2'b00) ? 2'b00 : ctr[upd_idx] - 2'b01;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch unit: PC/stall control, branch prediction at fetch and a circular
// instruction queue feeding the decoder.
import ifetch_queue_pkg::*;

module ifetch_queue #(
  parameter int IQ_DEPTH  = 8,
  parameter int BHT_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic [31:0] corr_pc,
  output logic        mc_fetch_en,
  output logic [31:0] mc_aout,
  output logic        mc_flush_out,
  input  logic        mc_instr_in_en,
  input  logic [31:0] mc_instr_in,
  output logic        de_out_en,
  input  logic        de_ready_in,
  output logic [31:0] de_pc_out,
  output logic [31:0] de_instr_out,
  output logic        de_pred_taken_out,
  output logic [31:0] de_pred_pc_out,
  input  logic        jalr_done_in,
  input  logic [31:0] jalr_pc_in,
  input  logic        bht_upd_en_in,
  input  logic [31:0] bht_upd_pc_in,
  input  logic        bht_upd_taken_in
);

  localparam int                IQ_PTR_W   = $clog2(IQ_DEPTH);
  localparam logic [IQ_PTR_W:0] FULL_COUNT = IQ_DEPTH[IQ_PTR_W:0];

  logic [31:0]         pc;
  logic                stall;
  logic [IQ_PTR_W-1:0] head, tail;
  logic [IQ_PTR_W:0]   count;

  logic [IQ_ENTRY_WIDTH-1:0] queue_mem [IQ_DEPTH];
  iq_entry_t                 head_entry;
  iq_entry_t                 new_entry;

  instr_kind_e kind;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        bht_taken;
  logic        accept;
  logic        pop;
  logic        unused_upd_bits;

  assign unused_upd_bits = ^{bht_upd_pc_in[31:BHT_IDX_W+2], bht_upd_pc_in[1:0]};

  branch_history_table #(.BHT_IDX_W(BHT_IDX_W)) u_bht (
    .clk       (clk),
    .rst_in    (rst_in),
    .en        (rdy_in),
    .rd_idx    (pc[BHT_IDX_W+1:2]),
    .rd_taken  (bht_taken),
    .upd_en    (bht_upd_en_in),
    .upd_idx   (bht_upd_pc_in[BHT_IDX_W+1:2]),
    .upd_taken (bht_upd_taken_in)
  );

  // Full-ness uses the start-of-cycle count, so a pop never frees a slot
  // for a same-cycle fetch.
  assign mc_fetch_en  = rst_in && rdy_in && !stall && (count != FULL_COUNT) && !roll_back;
  assign mc_flush_out = rst_in && rdy_in && roll_back;
  assign mc_aout      = pc;
  assign accept       = mc_fetch_en && mc_instr_in_en;
  assign de_out_en    = (count != '0);
  assign pop          = de_out_en && de_ready_in && rdy_in && !roll_back;

  assign head_entry        = queue_mem[head];
  assign de_pc_out         = head_entry.pc;
  assign de_instr_out      = head_entry.instr;
  assign de_pred_taken_out = head_entry.pred_taken;
  assign de_pred_pc_out    = head_entry.pred_pc;

  // Predict the next fetch address from the incoming instruction.
  always_comb begin
    kind                 = decode_kind(mc_instr_in);
    pc_plus4             = pc + 32'd4;
    next_pc              = pc_plus4;
    new_entry.pc         = pc;
    new_entry.instr      = mc_instr_in;
    new_entry.pred_taken = 1'b0;
    case (kind)
      KIND_B: begin
        if (bht_taken) begin
          next_pc              = pc + imm_b(mc_instr_in);
          new_entry.pred_taken = 1'b1;
        end
      end
      KIND_JAL: begin
        next_pc              = pc + imm_j(mc_instr_in);
        new_entry.pred_taken = 1'b1;
      end
      KIND_JALR: next_pc = pc;
      default:   next_pc = pc_plus4;
    endcase
    new_entry.pred_pc = (kind == KIND_JALR) ? pc_plus4 : next_pc;
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      pc    <= '0;
      stall <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (roll_back) begin
        pc    <= corr_pc;
        stall <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (accept) begin
          pc   <= next_pc;
          tail <= tail + 1'b1;
          if (kind == KIND_JALR) stall <= 1'b1;
        end else if (stall && jalr_done_in) begin
          pc    <= jalr_pc_in;
          stall <= 1'b0;
        end
        if (pop) head <= head + 1'b1;
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (accept) queue_mem[tail] <= new_entry;
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed self-checking bench for ifetch_queue with a small instruction memory.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic [31:0] corr_pc;
  logic        mc_fetch_en;
  logic [31:0] mc_aout;
  logic        mc_flush_out;
  logic        mc_instr_in_en;
  logic [31:0] mc_instr_in;
  logic        de_out_en;
  logic        de_ready_in;
  logic [31:0] de_pc_out;
  logic [31:0] de_instr_out;
  logic        de_pred_taken_out;
  logic [31:0] de_pred_pc_out;
  logic        jalr_done_in;
  logic [31:0] jalr_pc_in;
  logic        bht_upd_en_in;
  logic [31:0] bht_upd_pc_in;
  logic        bht_upd_taken_in;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ_P20  = 32'h0200_0063;
  localparam logic [31:0] JAL_M8   = 32'hFF9F_F06F;
  localparam logic [31:0] JALR_X1  = 32'h0000_8067;

  logic [31:0] imem [logic [31:0]];

  typedef struct {
    logic        instr_en;
    logic        de_ready;
    logic        exp_fetch_en;
    logic        exp_de_en;
    logic [31:0] exp_aout;
    logic [31:0] exp_de_pc;
  } vec_t;

  vec_t vecs[$];

  ifetch_queue #(.IQ_DEPTH(8), .BHT_IDX_W(6)) dut (
    .clk               (clk),
    .rst_in            (rst_in),
    .rdy_in            (rdy_in),
    .roll_back         (roll_back),
    .corr_pc           (corr_pc),
    .mc_fetch_en       (mc_fetch_en),
    .mc_aout           (mc_aout),
    .mc_flush_out      (mc_flush_out),
    .mc_instr_in_en    (mc_instr_in_en),
    .mc_instr_in       (mc_instr_in),
    .de_out_en         (de_out_en),
    .de_ready_in       (de_ready_in),
    .de_pc_out         (de_pc_out),
    .de_instr_out      (de_instr_out),
    .de_pred_taken_out (de_pred_taken_out),
    .de_pred_pc_out    (de_pred_pc_out),
    .jalr_done_in      (jalr_done_in),
    .jalr_pc_in        (jalr_pc_in),
    .bht_upd_en_in     (bht_upd_en_in),
    .bht_upd_pc_in     (bht_upd_pc_in),
    .bht_upd_taken_in  (bht_upd_taken_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fetch_word(input logic [31:0] addr);
    if (imem.exists(addr)) return imem[addr];
    return NOP;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one clock and present the memory word for the new fetch address.
  task automatic tick();
    @(posedge clk);
    #1;
    mc_instr_in = fetch_word(mc_aout);
  endtask

  task automatic do_reset();
    rst_in           = 1'b0;
    rdy_in           = 1'b1;
    roll_back        = 1'b0;
    corr_pc          = '0;
    mc_instr_in_en   = 1'b0;
    de_ready_in      = 1'b0;
    jalr_done_in     = 1'b0;
    jalr_pc_in       = '0;
    bht_upd_en_in    = 1'b0;
    bht_upd_pc_in    = '0;
    bht_upd_taken_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_in      = 1'b1;
    mc_instr_in = fetch_word(mc_aout);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    mc_instr_in_en = v.instr_en;
    de_ready_in    = v.de_ready;
    #1;
    check_output($sformatf("vec%0d.fetch_en", idx), {31'b0, mc_fetch_en}, {31'b0, v.exp_fetch_en});
    check_output($sformatf("vec%0d.de_en", idx), {31'b0, de_out_en}, {31'b0, v.exp_de_en});
    check_output($sformatf("vec%0d.aout", idx), mc_aout, v.exp_aout);
    if (v.exp_de_en) begin
      check_output($sformatf("vec%0d.de_pc", idx), de_pc_out, v.exp_de_pc);
      check_output($sformatf("vec%0d.de_pred_pc", idx), de_pred_pc_out, v.exp_de_pc + 32'd4);
    end
    tick();
  endtask

  task automatic bht_train(input int n, input logic taken);
    repeat (n) begin
      bht_upd_en_in    = 1'b1;
      bht_upd_pc_in    = 32'h10;
      bht_upd_taken_in = taken;
      tick();
    end
    bht_upd_en_in = 1'b0;
  endtask

  // Redirect to addr, fetch it, and check the prediction made for it.
  task automatic refetch(input string name, input logic [31:0] addr,
                         input logic exp_taken, input logic [31:0] exp_next);
    roll_back = 1'b1;
    corr_pc   = addr;
    #1;
    check_output({name, ".flush"}, {31'b0, mc_flush_out}, 32'd1);
    tick();
    roll_back = 1'b0;
    #1;
    check_output({name, ".aout_redirect"}, mc_aout, addr);
    tick();
    check_output({name, ".de_pc"}, de_pc_out, addr);
    check_output({name, ".pred_taken"}, {31'b0, de_pred_taken_out}, {31'b0, exp_taken});
    check_output({name, ".pred_pc"}, de_pred_pc_out, exp_next);
    check_output({name, ".aout_next"}, mc_aout, exp_next);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Straight-line fill, then a full queue held and drained one per cycle.
    vecs.push_back('{1, 1, 1, 0, 32'h00, 32'h00});
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{1, 1, 1, 1, 32'(4 * k), 32'(4 * (k - 1))});
    for (int k = 9; k <= 15; k++)
      vecs.push_back('{1, 0, 1, 1, 32'(32'h24 + 4 * (k - 9)), 32'h20});
    vecs.push_back('{1, 0, 0, 1, 32'h40, 32'h20});
    vecs.push_back('{1, 1, 0, 1, 32'h40, 32'h20});
    vecs.push_back('{1, 1, 1, 1, 32'h40, 32'h24});
    vecs.push_back('{1, 1, 1, 1, 32'h44, 32'h28});

    rst_in = 1'b0;
    rdy_in = 1'b1;
    roll_back = 1'b0;
    mc_instr_in_en = 1'b1;
    mc_instr_in = NOP;
    de_ready_in = 1'b1;
    corr_pc = '0;
    jalr_done_in = 1'b0;
    jalr_pc_in = '0;
    bht_upd_en_in = 1'b0;
    bht_upd_pc_in = '0;
    bht_upd_taken_in = 1'b0;
    #2;
    check_output("reset.fetch_en", {31'b0, mc_fetch_en}, 32'd0);
    check_output("reset.de_en", {31'b0, de_out_en}, 32'd0);
    check_output("reset.flush", {31'b0, mc_flush_out}, 32'd0);
    check_output("reset.aout", mc_aout, 32'd0);

    imem.delete();
    do_reset();
    foreach (vecs[i]) apply_stimulus(i, vecs[i]);

    // Branch prediction on a BEQ at 0x10 with offset +0x20.
    imem.delete();
    imem[32'h10] = BEQ_P20;
    do_reset();
    de_ready_in    = 1'b1;
    mc_instr_in_en = 1'b1;
    repeat (4) tick();
    check_output("beq.aout", mc_aout, 32'h10);
    tick();
    check_output("beq.de_pc", de_pc_out, 32'h10);
    check_output("beq.pred_taken_init", {31'b0, de_pred_taken_out}, 32'd0);
    check_output("beq.pred_pc_init", de_pred_pc_out, 32'h14);
    check_output("beq.aout_init", mc_aout, 32'h14);
    bht_train(3, 1'b1);
    refetch("beq_sat_hi", 32'h10, 1'b1, 32'h30);
    bht_train(1, 1'b0);
    refetch("beq_weak_t", 32'h10, 1'b1, 32'h30);
    bht_train(4, 1'b0);
    bht_train(1, 1'b1);
    refetch("beq_sat_lo", 32'h10, 1'b0, 32'h14);

    // JAL backwards into a JALR that stalls until resolved.
    imem.delete();
    imem[32'h0] = JALR_X1;
    imem[32'h8] = JAL_M8;
    do_reset();
    de_ready_in    = 1'b1;
    mc_instr_in_en = 1'b1;
    roll_back = 1'b1;
    corr_pc   = 32'h8;
    tick();
    roll_back = 1'b0;
    #1;
    check_output("jal.aout", mc_aout, 32'h8);
    tick();
    check_output("jal.no_bubble_aout", mc_aout, 32'h0);
    check_output("jal.no_bubble_fetch", {31'b0, mc_fetch_en}, 32'd1);
    check_output("jal.pred_taken", {31'b0, de_pred_taken_out}, 32'd1);
    check_output("jal.pred_pc", de_pred_pc_out, 32'h0);
    tick();
    check_output("jalr.stall_fetch", {31'b0, mc_fetch_en}, 32'd0);
    check_output("jalr.aout_held", mc_aout, 32'h0);
    check_output("jalr.de_pc", de_pc_out, 32'h0);
    check_output("jalr.pred_pc", de_pred_pc_out, 32'h4);
    check_output("jalr.pred_taken", {31'b0, de_pred_taken_out}, 32'd0);
    repeat (2) begin
      tick();
      check_output("jalr.still_stalled", {31'b0, mc_fetch_en}, 32'd0);
    end
    jalr_done_in = 1'b1;
    jalr_pc_in   = 32'h100;
    tick();
    jalr_done_in = 1'b0;
    #1;
    check_output("jalr.resume_aout", mc_aout, 32'h100);
    check_output("jalr.resume_fetch", {31'b0, mc_fetch_en}, 32'd1);
    tick();
    check_output("jalr.target_de_pc", de_pc_out, 32'h100);

    // Roll back with 5 queued entries and a pending JALR stall.
    imem.delete();
    imem[32'h10] = JALR_X1;
    do_reset();
    de_ready_in    = 1'b0;
    mc_instr_in_en = 1'b1;
    repeat (5) tick();
    check_output("rb.pre_stall", {31'b0, mc_fetch_en}, 32'd0);
    check_output("rb.pre_de_en", {31'b0, de_out_en}, 32'd1);
    check_output("rb.pre_de_pc", de_pc_out, 32'h0);
    roll_back    = 1'b1;
    corr_pc      = 32'h40;
    de_ready_in  = 1'b1;
    jalr_done_in = 1'b1;
    jalr_pc_in   = 32'h200;
    #1;
    check_output("rb.flush", {31'b0, mc_flush_out}, 32'd1);
    check_output("rb.fetch_blocked", {31'b0, mc_fetch_en}, 32'd0);
    tick();
    roll_back    = 1'b0;
    jalr_done_in = 1'b0;
    #1;
    check_output("rb.de_en", {31'b0, de_out_en}, 32'd0);
    check_output("rb.aout", mc_aout, 32'h40);
    check_output("rb.unstalled", {31'b0, mc_fetch_en}, 32'd1);
    check_output("rb.flush_once", {31'b0, mc_flush_out}, 32'd0);

    // Asynchronous reset between clock edges with a full queue.
    imem.delete();
    do_reset();
    de_ready_in    = 1'b0;
    mc_instr_in_en = 1'b1;
    repeat (8) tick();
    check_output("full.fetch_en", {31'b0, mc_fetch_en}, 32'd0);
    check_output("full.de_en", {31'b0, de_out_en}, 32'd1);
    #1;
    rst_in = 1'b0;
    #1;
    check_output("areset.de_en", {31'b0, de_out_en}, 32'd0);
    check_output("areset.fetch_en", {31'b0, mc_fetch_en}, 32'd0);
    check_output("areset.aout", mc_aout, 32'h0);

    // rdy_in low freezes everything for three cycles.
    do_reset();
    de_ready_in    = 1'b0;
    mc_instr_in_en = 1'b1;
    repeat (3) tick();
    rdy_in        = 1'b0;
    de_ready_in   = 1'b1;
    repeat (3) begin
      #1;
      check_output("freeze.fetch_en", {31'b0, mc_fetch_en}, 32'd0);
      check_output("freeze.aout", mc_aout, 32'hC);
      check_output("freeze.de_pc", de_pc_out, 32'h0);
      check_output("freeze.de_en", {31'b0, de_out_en}, 32'd1);
      tick();
    end
    rdy_in = 1'b1;
    #1;
    check_output("thaw.fetch_en", {31'b0, mc_fetch_en}, 32'd1);
    check_output("thaw.aout", mc_aout, 32'hC);
    tick();
    check_output("thaw.de_pc", de_pc_out, 32'h4);
    check_output("thaw.aout_next", mc_aout, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
